// File: rtl/axi_out_watchdog.sv
// Outbound AXI progress watchdog: zero-latency pass-through, per-direction outstanding
// limiter, and stall timer that trips an isolation request plus interrupt.

package axi_out_watchdog_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned UserWidth = 1;

  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [UserWidth-1:0]   user_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    user_t       user;
  } axi_out_aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } axi_out_w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } axi_out_b_chan_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    user_t       user;
  } axi_out_ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } axi_out_r_chan_t;

  typedef struct packed {
    axi_out_aw_chan_t aw;
    logic             aw_valid;
    axi_out_w_chan_t  w;
    logic             w_valid;
    logic             b_ready;
    axi_out_ar_chan_t ar;
    logic             ar_valid;
    logic             r_ready;
  } axi_out_req_t;

  typedef struct packed {
    logic            aw_ready;
    logic            ar_ready;
    logic            w_ready;
    logic            b_valid;
    axi_out_b_chan_t b;
    logic            r_valid;
    axi_out_r_chan_t r;
  } axi_out_resp_t;

endpackage

module axi_out_watchdog #(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned TimerWidth     = 24,
  parameter type         axi_req_t      = axi_out_watchdog_pkg::axi_out_req_t,
  parameter type         axi_resp_t     = axi_out_watchdog_pkg::axi_out_resp_t
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  axi_req_t                                slv_req_i,
  output axi_resp_t                               slv_resp_o,
  output axi_req_t                                mst_req_o,
  input  axi_resp_t                               mst_resp_i,
  input  logic [TimerWidth-1:0]                   timeout_cycles_i,
  input  logic                                    clear_i,
  input  logic                                    isolated_i,
  output logic                                    isolate_req_o,
  output logic                                    timeout_o,
  output logic                                    irq_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]     wr_outstanding_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]     rd_outstanding_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_TRIP,
    ST_ISOLATED
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CntWidth-1:0]   rd_cnt_q, rd_cnt_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic                  isolate_req_q, isolate_req_d;
  logic                  timeout_q, timeout_d;
  logic                  irq_q, irq_d;

  logic wr_full, rd_full, idle, trip;
  logic aw_hs, b_hs, ar_hs, r_hs, r_last_hs;

  // Gating only looks at registered counts so ready never feeds back into valid.
  assign wr_full = (wr_cnt_q == MaxCnt);
  assign rd_full = (rd_cnt_q == MaxCnt);
  assign idle    = (wr_cnt_q == '0) && (rd_cnt_q == '0);

  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;
    if (wr_full) begin
      mst_req_o.aw_valid  = 1'b0;
      slv_resp_o.aw_ready = 1'b0;
    end
    if (rd_full) begin
      mst_req_o.ar_valid  = 1'b0;
      slv_resp_o.ar_ready = 1'b0;
    end
  end

  assign aw_hs     = slv_req_i.aw_valid && !wr_full && mst_resp_i.aw_ready;
  assign ar_hs     = slv_req_i.ar_valid && !rd_full && mst_resp_i.ar_ready;
  assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;
  assign r_hs      = mst_resp_i.r_valid && slv_req_i.r_ready;
  assign r_last_hs = r_hs && mst_resp_i.r.last;

  // A response arriving at zero count is treated as stray and ignored.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (aw_hs && !b_hs) begin
      wr_cnt_d = wr_cnt_q + CntWidth'(1);
    end else if (!aw_hs && b_hs && (wr_cnt_q != '0)) begin
      wr_cnt_d = wr_cnt_q - CntWidth'(1);
    end

    rd_cnt_d = rd_cnt_q;
    if (ar_hs && !r_last_hs) begin
      rd_cnt_d = rd_cnt_q + CntWidth'(1);
    end else if (!ar_hs && r_last_hs && (rd_cnt_q != '0)) begin
      rd_cnt_d = rd_cnt_q - CntWidth'(1);
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (b_hs || r_hs || idle) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TimerWidth'(1);
    end
  end

  assign trip = (timeout_cycles_i != '0) && (timer_q >= timeout_cycles_i);

  always_comb begin
    state_d       = state_q;
    irq_d         = 1'b0;
    timeout_d     = timeout_q;
    isolate_req_d = isolate_req_q;
    unique case (state_q)
      ST_RUN: begin
        if (trip) begin
          state_d       = ST_TRIP;
          irq_d         = 1'b1;
          timeout_d     = 1'b1;
          isolate_req_d = 1'b1;
        end
      end
      ST_TRIP: begin
        if (isolated_i) begin
          state_d = ST_ISOLATED;
        end
      end
      ST_ISOLATED: begin
        // Leaving isolation with transactions still counted would corrupt the limiter.
        if (clear_i && idle) begin
          state_d       = ST_RUN;
          timeout_d     = 1'b0;
          isolate_req_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_RUN;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      timer_q       <= '0;
      isolate_req_q <= 1'b0;
      timeout_q     <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      timer_q       <= timer_d;
      isolate_req_q <= isolate_req_d;
      timeout_q     <= timeout_d;
      irq_q         <= irq_d;
    end
  end

  assign isolate_req_o    = isolate_req_q;
  assign timeout_o        = timeout_q;
  assign irq_o            = irq_q;
  assign wr_outstanding_o = wr_cnt_q;
  assign rd_outstanding_o = rd_cnt_q;

endmodule

// File: tb/tb_axi_out_watchdog.sv
// Directed bench for axi_out_watchdog: stimulus queues expected values, a negedge monitor compares.

module tb_axi_out_watchdog;
  import axi_out_watchdog_pkg::*;

  localparam int unsigned MaxOut = 2;
  localparam int unsigned TW     = 24;

  localparam logic [3:0] SIG_WR    = 4'd0;
  localparam logic [3:0] SIG_RD    = 4'd1;
  localparam logic [3:0] SIG_IRQ   = 4'd2;
  localparam logic [3:0] SIG_TMO   = 4'd3;
  localparam logic [3:0] SIG_ISO   = 4'd4;
  localparam logic [3:0] SIG_AWRDY = 4'd5;
  localparam logic [3:0] SIG_AWVLD = 4'd6;
  localparam logic [3:0] SIG_WDATA = 4'd7;
  localparam logic [3:0] SIG_BRESP = 4'd8;
  localparam logic [3:0] SIG_RRESP = 4'd9;

  typedef struct packed {
    logic [3:0]  sig;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst_n;
  axi_out_req_t  slv_req, mst_req;
  axi_out_resp_t slv_resp, mst_resp;
  logic [TW-1:0] timeout_cycles;
  logic clear, isolated;
  logic isolate_req, timeout_flag, irq;
  logic [$clog2(MaxOut+1)-1:0] wr_out, rd_out;

  exp_t exp_q[$];
  int   num_checks = 0;
  int   num_errors = 0;

  axi_out_watchdog #(
    .MaxOutstanding (MaxOut),
    .TimerWidth     (TW),
    .axi_req_t      (axi_out_req_t),
    .axi_resp_t     (axi_out_resp_t)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .slv_req_i        (slv_req),
    .slv_resp_o       (slv_resp),
    .mst_req_o        (mst_req),
    .mst_resp_i       (mst_resp),
    .timeout_cycles_i (timeout_cycles),
    .clear_i          (clear),
    .isolated_i       (isolated),
    .isolate_req_o    (isolate_req),
    .timeout_o        (timeout_flag),
    .irq_o            (irq),
    .wr_outstanding_o (wr_out),
    .rd_outstanding_o (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL sim_timeout: got no end of test, expected end within 1 ms");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  function automatic string sig_name(input logic [3:0] s);
    case (s)
      SIG_WR:    return "wr_outstanding";
      SIG_RD:    return "rd_outstanding";
      SIG_IRQ:   return "irq";
      SIG_TMO:   return "timeout";
      SIG_ISO:   return "isolate_req";
      SIG_AWRDY: return "slv_aw_ready";
      SIG_AWVLD: return "mst_aw_valid";
      SIG_WDATA: return "mst_w_data";
      SIG_BRESP: return "slv_b_resp";
      SIG_RRESP: return "slv_r_resp";
      default:   return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual(input logic [3:0] s);
    case (s)
      SIG_WR:    return 32'(wr_out);
      SIG_RD:    return 32'(rd_out);
      SIG_IRQ:   return 32'(irq);
      SIG_TMO:   return 32'(timeout_flag);
      SIG_ISO:   return 32'(isolate_req);
      SIG_AWRDY: return 32'(slv_resp.aw_ready);
      SIG_AWVLD: return 32'(mst_req.aw_valid);
      SIG_WDATA: return mst_req.w.data[31:0];
      SIG_BRESP: return 32'(slv_resp.b.resp);
      SIG_RRESP: return 32'(slv_resp.r.resp);
      default:   return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: every queued expectation is compared at the next falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      act = actual(e.sig);
      num_checks++;
      if (act !== e.exp) begin
        num_errors++;
        $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", sig_name(e.sig), $time, act, e.exp);
      end
    end
  end

  task automatic checkOutput(input logic [3:0] s, input logic [31:0] value);
    exp_q.push_back('{sig: s, exp: value});
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    slv_req        = '0;
    mst_resp       = '0;
    slv_req.b_ready  = 1'b1;
    slv_req.r_ready  = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.ar_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    timeout_cycles = '0;
    clear          = 1'b0;
    isolated       = 1'b0;

    $display("[TB] reset values");
    checkOutput(SIG_WR, 0);
    checkOutput(SIG_RD, 0);
    checkOutput(SIG_IRQ, 0);
    checkOutput(SIG_TMO, 0);
    checkOutput(SIG_ISO, 0);
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(1);

    $display("[TB] limiter");
    slv_req.aw_valid = 1'b1;
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 64'hDEAD_BEEF_0123_4567;
    checkOutput(SIG_AWRDY, 1);
    checkOutput(SIG_WR, 0);
    checkOutput(SIG_WDATA, 32'h0123_4567);
    applyStimulus(1);
    slv_req.w_valid = 1'b0;
    checkOutput(SIG_WR, 1);
    checkOutput(SIG_AWRDY, 1);
    applyStimulus(1);
    checkOutput(SIG_WR, 2);
    checkOutput(SIG_AWRDY, 0);
    checkOutput(SIG_AWVLD, 0);
    applyStimulus(1);
    checkOutput(SIG_WR, 2);
    checkOutput(SIG_AWRDY, 0);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.resp  = 2'b10;
    checkOutput(SIG_BRESP, 2);
    applyStimulus(1);
    mst_resp.b_valid = 1'b0;
    checkOutput(SIG_WR, 1);
    checkOutput(SIG_AWRDY, 1);
    checkOutput(SIG_AWVLD, 1);
    applyStimulus(1);
    slv_req.aw_valid = 1'b0;
    checkOutput(SIG_WR, 2);
    mst_resp.b_valid = 1'b1;
    applyStimulus(2);
    mst_resp.b_valid = 1'b0;
    checkOutput(SIG_WR, 0);
    checkOutput(SIG_TMO, 0);

    $display("[TB] simultaneous AR and R-last");
    timeout_cycles = 4;
    slv_req.ar_valid = 1'b1;
    applyStimulus(1);
    slv_req.ar_valid = 1'b0;
    checkOutput(SIG_RD, 1);
    applyStimulus(2);
    checkOutput(SIG_TMO, 0);
    slv_req.ar_valid = 1'b1;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    applyStimulus(1);
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b0;
    checkOutput(SIG_RD, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkOutput(SIG_TMO, 0);
      checkOutput(SIG_IRQ, 0);
    end
    mst_resp.r_valid = 1'b1;
    applyStimulus(1);
    mst_resp.r_valid = 1'b0;
    checkOutput(SIG_RD, 0);
    checkOutput(SIG_TMO, 0);
    applyStimulus(2);
    checkOutput(SIG_TMO, 0);
    checkOutput(SIG_IRQ, 0);

    $display("[TB] trip after 16 stalled cycles");
    timeout_cycles = 16;
    slv_req.ar_valid = 1'b1;
    applyStimulus(1);
    slv_req.ar_valid = 1'b0;
    checkOutput(SIG_RD, 1);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1);
      checkOutput(SIG_IRQ, 0);
      checkOutput(SIG_TMO, 0);
    end
    applyStimulus(1);
    num_checks++;
    if (irq !== 1'b1 || timeout_flag !== 1'b1 || isolate_req !== 1'b1) begin
      num_errors++;
      $display("[TB] FAIL trip at %0t: got irq=%b timeout=%b isolate_req=%b, expected 1 1 1",
               $time, irq, timeout_flag, isolate_req);
    end
    checkOutput(SIG_IRQ, 1);
    checkOutput(SIG_TMO, 1);
    checkOutput(SIG_ISO, 1);
    applyStimulus(1);
    checkOutput(SIG_IRQ, 0);
    checkOutput(SIG_TMO, 1);
    checkOutput(SIG_ISO, 1);

    $display("[TB] recovery");
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0;
    checkOutput(SIG_TMO, 1);
    checkOutput(SIG_ISO, 1);
    isolated = 1'b1;
    applyStimulus(1);
    isolated = 1'b0;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    mst_resp.r.resp  = 2'b10;
    checkOutput(SIG_RRESP, 2);
    applyStimulus(1);
    mst_resp.r_valid = 1'b0;
    checkOutput(SIG_RD, 0);
    checkOutput(SIG_TMO, 1);
    checkOutput(SIG_ISO, 1);
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0;
    num_checks++;
    if (timeout_flag !== 1'b0 || isolate_req !== 1'b0) begin
      num_errors++;
      $display("[TB] FAIL recovery at %0t: got timeout=%b isolate_req=%b, expected 0 0",
               $time, timeout_flag, isolate_req);
    end
    checkOutput(SIG_TMO, 0);
    checkOutput(SIG_ISO, 0);
    checkOutput(SIG_IRQ, 0);

    $display("[TB] clear ignored with writes outstanding");
    timeout_cycles = 3;
    slv_req.aw_valid = 1'b1;
    applyStimulus(1);
    slv_req.aw_valid = 1'b0;
    checkOutput(SIG_WR, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkOutput(SIG_IRQ, 0);
    end
    applyStimulus(1);
    checkOutput(SIG_IRQ, 1);
    checkOutput(SIG_TMO, 1);
    isolated = 1'b1;
    applyStimulus(1);
    isolated = 1'b0;
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0;
    checkOutput(SIG_TMO, 1);
    checkOutput(SIG_ISO, 1);
    applyStimulus(1);
    checkOutput(SIG_TMO, 1);
    mst_resp.b_valid = 1'b1;
    applyStimulus(1);
    mst_resp.b_valid = 1'b0;
    checkOutput(SIG_WR, 0);
    checkOutput(SIG_TMO, 1);
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0;
    checkOutput(SIG_TMO, 0);
    checkOutput(SIG_ISO, 0);

    $display("[TB] watchdog disabled, then threshold lowered");
    timeout_cycles = 0;
    slv_req.aw_valid = 1'b1;
    applyStimulus(1);
    slv_req.aw_valid = 1'b0;
    checkOutput(SIG_WR, 1);
    applyStimulus(2000);
    checkOutput(SIG_TMO, 0);
    checkOutput(SIG_ISO, 0);
    checkOutput(SIG_IRQ, 0);
    timeout_cycles = 100;
    applyStimulus(1);
    checkOutput(SIG_IRQ, 1);
    checkOutput(SIG_TMO, 1);

    $display("[TB] asynchronous reset mid-burst");
    slv_req.ar_valid = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    checkOutput(SIG_WR, 0);
    checkOutput(SIG_RD, 0);
    checkOutput(SIG_IRQ, 0);
    checkOutput(SIG_TMO, 0);
    checkOutput(SIG_ISO, 0);
    checkOutput(SIG_AWRDY, 1);
    applyStimulus(2);
    slv_req.ar_valid = 1'b0;
    rst_n = 1'b1;
    applyStimulus(2);
    checkOutput(SIG_RD, 0);
    checkOutput(SIG_TMO, 0);

    @(negedge clk);
    #1;
    if (num_errors != 0) begin
      $display("[TB] FAIL summary: got %0d errors, expected 0", num_errors);
    end
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
